// File: rtl/hyperbus_delay_tuner.sv
// HyperBus strobe/clock delay tuner: per-channel clock-mux tap trees whose select
// codes are ramped one LSB at a time toward a requested code, with idle gaps between steps.

module CKMUX2M2R (
    input  logic I0,
    input  logic I1,
    input  logic S,
    output logic Z
);
    assign Z = S ? I1 : I0;
endmodule

module hbdt_chan #(
    parameter int TAP_W = 3
) (
    input  logic [TAP_W-1:0] sel_i,
    input  logic             sig_i,
    output logic             sig_o
);
    localparam int NT = 2**TAP_W;

    // Tap delays come from the physical placement/routing of the tap cells,
    // so logically every tap carries the same signal.
    logic [NT-1:0] tap;
    assign tap = {NT{sig_i}};

    for (genvar k = 0; k < TAP_W; k++) begin : g_lvl
        localparam int N = 2**(TAP_W-1-k);
        logic [N-1:0] y;
        for (genvar j = 0; j < N; j++) begin : g_mux
            logic a, b;
            if (k == 0) begin : g_leaf
                assign a = tap[2*j];
                assign b = tap[2*j+1];
            end else begin : g_node
                assign a = g_lvl[k-1].y[2*j];
                assign b = g_lvl[k-1].y[2*j+1];
            end
            CKMUX2M2R u_mux (.I0(a), .I1(b), .S(sel_i[k]), .Z(y[j]));
        end
    end

    assign sig_o = g_lvl[TAP_W-1].y[0];
endmodule

module hyperbus_delay_tuner #(
    parameter int NUM_CH    = 2,
    parameter int TAP_W     = 3,
    parameter int RST_CODE  = 0,
    parameter int STEP_WAIT = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [2:0]              cfg_ch_i,
    input  logic [TAP_W-1:0]        cfg_code_i,
    output logic                    busy_o,
    output logic [NUM_CH*TAP_W-1:0] cur_code_o,
    input  logic [NUM_CH-1:0]       sig_i,
    output logic [NUM_CH-1:0]       sig_o
);
    typedef enum logic [1:0] {IDLE, STEP, WAIT} state_e;

    localparam logic [TAP_W-1:0] RST_C = TAP_W'(RST_CODE);
    localparam logic [3:0]       WLAST = 4'((STEP_WAIT > 0) ? STEP_WAIT - 1 : 0);

    state_e                         state_q, state_d;
    logic [NUM_CH-1:0][TAP_W-1:0]   code_q, code_d;
    logic [TAP_W-1:0]               tgt_q, tgt_d;
    logic [2:0]                     ch_q, ch_d;
    logic [3:0]                     wcnt_q, wcnt_d;

    logic [TAP_W-1:0] cfg_cur, act, stepped;
    logic             ch_ok;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tgt_d   = tgt_q;
        ch_d    = ch_q;
        wcnt_d  = wcnt_q;
        cfg_cur = '0;
        ch_ok   = 1'b0;
        act     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch_i == 3'(c)) begin
                ch_ok   = 1'b1;
                cfg_cur = code_q[c];
            end
            if (ch_q == 3'(c)) act = code_q[c];
        end
        // Only ever one LSB toward the target, so the code can never wrap.
        stepped = (tgt_q > act) ? act + 1'b1 : act - 1'b1;

        case (state_q)
            IDLE: begin
                if (cfg_valid_i && ch_ok && (cfg_code_i != cfg_cur)) begin
                    ch_d    = cfg_ch_i;
                    tgt_d   = cfg_code_i;
                    state_d = STEP;
                end
            end
            STEP: begin
                for (int c = 0; c < NUM_CH; c++)
                    if (ch_q == 3'(c)) code_d[c] = stepped;
                wcnt_d = '0;
                if (STEP_WAIT > 0)        state_d = WAIT;
                else if (stepped != tgt_q) state_d = STEP;
                else                       state_d = IDLE;
            end
            WAIT: begin
                if (wcnt_q == WLAST) begin
                    wcnt_d  = '0;
                    state_d = (act != tgt_q) ? STEP : IDLE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            code_q  <= {NUM_CH{RST_C}};
            tgt_q   <= RST_C;
            ch_q    <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            tgt_q   <= tgt_d;
            ch_q    <= ch_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = ~cfg_ready_o;
    assign cur_code_o  = code_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        hbdt_chan #(.TAP_W(TAP_W)) u_ch (
            .sel_i (code_q[c]),
            .sig_i (sig_i[c]),
            .sig_o (sig_o[c])
        );
    end
endmodule

// File: tb/tb_hyperbus_delay_tuner.sv
// Directed bench: default tuner (STEP_WAIT=2) plus a STEP_WAIT=0 instance.

module tb_hyperbus_delay_tuner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [2:0] ch0 = '0, ch1 = '0;
    logic [2:0] cd0 = '0, cd1 = '0;
    logic       rdy0, rdy1, busy0, busy1;
    logic [5:0] cur0, cur1;
    logic [1:0] si0 = '0, si1 = '0, so0, so1;
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    hyperbus_delay_tuner u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(v0), .cfg_ready_o(rdy0),
        .cfg_ch_i(ch0), .cfg_code_i(cd0), .busy_o(busy0), .cur_code_o(cur0),
        .sig_i(si0), .sig_o(so0)
    );

    hyperbus_delay_tuner #(.STEP_WAIT(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(v1), .cfg_ready_o(rdy1),
        .cfg_ch_i(ch1), .cfg_code_i(cd1), .busy_o(busy1), .cur_code_o(cur1),
        .sig_i(si1), .sig_o(so1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rdy0 !== 1'b1 || busy0 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs got rdy0=%b busy0=%b rdy1=%b busy1=%b exp 1 0 1 0", rdy0, busy0, rdy1, busy1);
        end
        n_tests++;
        if (cur0 !== 6'd0 || cur1 !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_code got %h/%h exp 00/00", cur0, cur1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sig(input string tag);
        logic [1:0] p;
        for (int i = 0; i < 4; i++) begin
            p = 2'(i);
            si0 = p; si1 = ~p;
            #1;
            n_tests++;
            if (so0 !== p || so1 !== ~p) begin
                n_fail++;
                $display("FAIL sig_%s got %b/%b exp %b/%b", tag, so0, so1, p, ~p);
            end
        end
    endtask

    task automatic test_ramp_up();
        int e;
        v0 = 1'b1; ch0 = 3'd0; cd0 = 3'd5;
        @(posedge clk); #1;
        v0 = 1'b0;
        n_tests++;
        if (rdy0 !== 1'b0 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL up_start got rdy=%b busy=%b exp 0 1", rdy0, busy0);
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            e = (k + 2) / 3;
            if (e > 5) e = 5;
            n_tests++;
            if (cur0[2:0] !== 3'(e) || cur0[5:3] !== 3'd0) begin
                n_fail++;
                $display("FAIL up_code k=%0d got ch0=%0d ch1=%0d exp %0d 0", k, cur0[2:0], cur0[5:3], e);
            end
            n_tests++;
            if (rdy0 !== (k >= 15)) begin
                n_fail++;
                $display("FAIL up_ready k=%0d got %b exp %b", k, rdy0, (k >= 15));
            end
        end
    endtask

    task automatic test_ramp_down();
        int e;
        v0 = 1'b1; ch0 = 3'd0; cd0 = 3'd2;
        @(posedge clk); #1;
        v0 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            e = (k + 2) / 3;
            if (e > 3) e = 3;
            e = 5 - e;
            n_tests++;
            if (cur0[2:0] !== 3'(e) || cur0[2:0] < 3'd2 || cur0[2:0] > 3'd5) begin
                n_fail++;
                $display("FAIL down_code k=%0d got %0d exp %0d", k, cur0[2:0], e);
            end
            n_tests++;
            if (rdy0 !== (k >= 9)) begin
                n_fail++;
                $display("FAIL down_ready k=%0d got %b exp %b", k, rdy0, (k >= 9));
            end
        end
    endtask

    task automatic test_noop(input logic [2:0] ch, input logic [2:0] cd, input string tag);
        v0 = 1'b1; ch0 = ch; cd0 = cd;
        @(posedge clk); #1;
        v0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (rdy0 !== 1'b1 || cur0 !== {3'd0, 3'd2}) begin
                n_fail++;
                $display("FAIL noop_%s k=%0d got rdy=%b cur=%h exp 1 02", tag, k, rdy0, cur0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int e0, e1;
        logic er;
        v1 = 1'b1; ch1 = 3'd0; cd1 = 3'd7;
        @(posedge clk); #1;
        v1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            e0 = (k > 7) ? 7 : k;
            e1 = (k <= 8) ? 0 : ((k - 8 > 3) ? 3 : k - 8);
            er = (k == 7) || (k >= 11);
            n_tests++;
            if (cur1[2:0] !== 3'(e0) || cur1[5:3] !== 3'(e1)) begin
                n_fail++;
                $display("FAIL b2b_code k=%0d got %0d/%0d exp %0d/%0d", k, cur1[2:0], cur1[5:3], e0, e1);
            end
            n_tests++;
            if (rdy1 !== er || busy1 !== ~er) begin
                n_fail++;
                $display("FAIL b2b_ready k=%0d got %b/%b exp %b", k, rdy1, busy1, er);
            end
            if (k == 2) begin v1 = 1'b1; ch1 = 3'd1; cd1 = 3'd3; end
            if (k == 8) v1 = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int e;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b1; ch0 = 3'd0; cd0 = 3'd7;
        @(posedge clk); #1;
        v0 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            e = (k + 2) / 3;
            n_tests++;
            if (cur0[2:0] !== 3'(e)) begin
                n_fail++;
                $display("FAIL mid_code k=%0d got %0d exp %0d", k, cur0[2:0], e);
            end
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (cur0 !== 6'd0 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async got cur=%h rdy=%b busy=%b exp 00 1 0", cur0, rdy0, busy0);
        end
        test_sig("inrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (cur0 !== 6'd0 || rdy0 !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_after k=%0d got cur=%h rdy=%b exp 00 1", k, cur0, rdy0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sig("rst");
        test_ramp_up();
        test_sig("c5");
        test_ramp_down();
        test_noop(3'd1, 3'd0, "same");
        test_noop(3'd7, 3'd3, "badch");
        test_back_to_back();
        test_sig("c7");
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
